// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - decode-side and execute-side handshake bundle for imm_extend_pipe
interface imm_extend_pipe_if #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IMM_W-1:0] in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate extension stage with 2-entry skid buffer; IMM_EXT_OVF_EN adds out_ovf
module imm_extend_pipe #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_extend_pipe_if.slave bus,
    output logic [1:0]       occupancy
`ifdef IMM_EXT_OVF_EN
    ,
    output logic             out_ovf
`endif
);
    localparam int S = OUT_W - IMM_W;

    logic [OUT_W-1:0] se;
    logic [OUT_W-1:0] ext_data;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;
    logic [TAG_W-1:0] skid_tag;
    logic             accept;
    logic             emit;
`ifdef IMM_EXT_OVF_EN
    logic [OUT_W+1:0] prod;
    logic             ext_ovf;
    logic             out_ovf_q;
    logic             skid_ovf;
`endif

    always_comb begin
        se = {OUT_W{bus.in_imm[IMM_W-1]}};
        se[IMM_W-1:0] = bus.in_imm;
`ifdef IMM_EXT_OVF_EN
        // Branch offset computed two bits wider so the lost high bits can be inspected.
        prod    = {se[OUT_W-1], se[OUT_W-1], se} << 2;
        ext_ovf = (bus.in_mode == 2'b11) &&
                  ((prod[OUT_W+1] != prod[OUT_W-1]) || (prod[OUT_W] != prod[OUT_W-1]));
`endif
        case (bus.in_mode)
            2'b00:   ext_data = OUT_W'(bus.in_imm);
            2'b01:   ext_data = se;
            2'b10:   ext_data = OUT_W'(bus.in_imm) << S;
            default: ext_data = se << 2;
        endcase
    end

    assign accept = bus.in_valid & ~skid_valid;
    assign emit   = out_valid_q & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_tag    <= '0;
`ifdef IMM_EXT_OVF_EN
            out_ovf_q   <= 1'b0;
            skid_ovf    <= 1'b0;
`endif
        end else if (skid_valid && emit) begin
            out_data_q <= skid_data;
            out_tag_q  <= skid_tag;
            skid_valid <= 1'b0;
`ifdef IMM_EXT_OVF_EN
            out_ovf_q  <= skid_ovf;
`endif
        end else if ((!out_valid_q || emit) && accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= ext_data;
            out_tag_q   <= bus.in_tag;
`ifdef IMM_EXT_OVF_EN
            out_ovf_q   <= ext_ovf;
`endif
        end else if (accept) begin
            // Output register is stalled: park the new entry behind it.
            skid_valid <= 1'b1;
            skid_data  <= ext_data;
            skid_tag   <= bus.in_tag;
`ifdef IMM_EXT_OVF_EN
            skid_ovf   <= ext_ovf;
`endif
        end else if (emit) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ~skid_valid;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign occupancy     = {1'b0, out_valid_q} + {1'b0, skid_valid};
`ifdef IMM_EXT_OVF_EN
    assign out_ovf       = out_ovf_q;
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - randomized self-checking bench for imm_extend_pipe against a queue reference model
module tb_imm_extend_pipe;
    localparam int IW = 16;
    localparam int OW = 32;
    localparam int TW = 5;

    typedef struct {
        logic [OW-1:0] data;
        logic [TW-1:0] tag;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] occupancy;
    int         checks = 0;
    int         failures = 0;
    entry_t     q[$];

    imm_extend_pipe_if #(.IMM_W(IW), .OUT_W(OW), .TAG_W(TW)) bus ();

`ifdef IMM_EXT_OVF_EN
    logic       out_ovf;
    logic [1:0] occupancy16;
    logic       ovf16;
    imm_extend_pipe_if #(.IMM_W(16), .OUT_W(16), .TAG_W(TW)) bus16 ();
    imm_extend_pipe #(.IMM_W(16), .OUT_W(16), .TAG_W(TW)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16), .occupancy(occupancy16), .out_ovf(ovf16)
    );
`endif

    imm_extend_pipe #(.IMM_W(IW), .OUT_W(OW), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .occupancy(occupancy)
`ifdef IMM_EXT_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference extension from the arithmetic meaning of each mode.
    function automatic logic [OW-1:0] ref_ext(input logic [IW-1:0] imm, input logic [1:0] mode);
        longint s;
        longint r;
        s = (longint'(imm) >= (64'sd1 <<< (IW-1))) ? longint'(imm) - (64'sd1 <<< IW) : longint'(imm);
        case (mode)
            2'b00:   r = longint'(imm);
            2'b01:   r = s;
            2'b10:   r = longint'(imm) * (64'sd1 <<< (OW-IW));
            default: r = s * 4;
        endcase
        return r[OW-1:0];
    endfunction

    // One clock: drive inputs, compare DUT state with the model, advance model past the edge.
    task automatic cycle(input bit v, input logic [IW-1:0] imm, input logic [1:0] mode,
                         input logic [TW-1:0] tag, input bit rdy, input bit rst);
        bit     emit;
        bit     acc;
        entry_t e;
        bus.in_valid  = v;
        bus.in_imm    = imm;
        bus.in_mode   = mode;
        bus.in_tag    = tag;
        bus.out_ready = rdy;
        rst_n         = !rst;
        check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
        check("occupancy", 64'(occupancy), 64'(q.size()));
        if (q.size() > 0) begin
            check("out_data", 64'(bus.out_data), 64'(q[0].data));
            check("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
        end
`ifdef IMM_EXT_OVF_EN
        check("out_ovf_32", 64'(out_ovf), 64'd0);
`endif
        emit = (q.size() > 0) && rdy;
        acc  = v && (q.size() < 2);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
        end else begin
            if (emit) void'(q.pop_front());
            if (acc) begin
                e.data = ref_ext(imm, mode);
                e.tag  = tag;
                q.push_back(e);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bit             hold;
        bit             v;
        bit             rdy;
        logic [IW-1:0]  imm;
        logic [1:0]     mode;
        logic [TW-1:0]  tag;

        bus.in_valid = 1'b0; bus.in_imm = '0; bus.in_mode = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
`ifdef IMM_EXT_OVF_EN
        bus16.in_valid = 1'b0; bus16.in_imm = '0; bus16.in_mode = '0; bus16.in_tag = '0;
        bus16.out_ready = 1'b1;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed mode values
        cycle(1, 16'h8001, 2'b01, 5'd3, 1, 0);
        check("mode01", 64'(bus.out_data), 64'h0000_0000_FFFF_8001);
        check("mode01_tag", 64'(bus.out_tag), 64'd3);
        cycle(1, 16'h8001, 2'b00, 5'd4, 1, 0);
        check("mode00", 64'(bus.out_data), 64'h0000_8001);
        cycle(1, 16'h1234, 2'b10, 5'd5, 1, 0);
        check("mode10", 64'(bus.out_data), 64'h1234_0000);
        cycle(1, 16'hFFFF, 2'b11, 5'd6, 1, 0);
        check("mode11", 64'(bus.out_data), 64'hFFFF_FFFC);
        cycle(0, '0, 2'b00, '0, 1, 0);

        // Backpressure: A, B accepted, C held
        cycle(1, 16'h000A, 2'b00, 5'd10, 0, 0);
        cycle(1, 16'h000B, 2'b00, 5'd11, 0, 0);
        cycle(1, 16'h000C, 2'b00, 5'd12, 0, 0);
        check("bp_occupancy", 64'(occupancy), 64'd2);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_head", 64'(bus.out_data), 64'h000A);
        repeat (3) cycle(1, 16'h000C, 2'b00, 5'd12, 1, 0);
        repeat (3) cycle(0, '0, 2'b00, '0, 1, 0);
        check("bp_drained", 64'(occupancy), 64'd0);

        // Streaming
        for (int i = 0; i < 8; i++) begin
            cycle(1, IW'($urandom), 2'($urandom), TW'(i), 1, 0);
            check("stream_in_ready", 64'(bus.in_ready), 64'd1);
            check("stream_occ", 64'(occupancy), 64'd1);
        end
        cycle(0, '0, 2'b00, '0, 1, 0);

        // Reset while full
        cycle(1, 16'h0111, 2'b01, 5'd1, 0, 0);
        cycle(1, 16'h0222, 2'b01, 5'd2, 0, 0);
        check("pre_rst_occ", 64'(occupancy), 64'd2);
        cycle(0, '0, 2'b00, '0, 0, 1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_occ", 64'(occupancy), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (3) cycle(0, '0, 2'b00, '0, 1, 0);

`ifdef IMM_EXT_OVF_EN
        bus16.in_valid = 1'b1; bus16.in_imm = 16'h4000; bus16.in_mode = 2'b11;
        @(posedge clk); #1;
        check("ovf_4000_data", 64'(bus16.out_data), 64'h0000);
        check("ovf_4000_flag", 64'(ovf16), 64'd1);
        bus16.in_imm = 16'hF000;
        @(posedge clk); #1;
        check("ovf_F000_data", 64'(bus16.out_data), 64'hC000);
        check("ovf_F000_flag", 64'(ovf16), 64'd0);
        bus16.in_valid = 1'b0;
        @(posedge clk); #1;
`endif

        // Random valid/ready traffic; upstream holds an offer until accepted
        hold = 0; imm = '0; mode = '0; tag = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!hold) begin
                v    = ($urandom % 3) != 0;
                imm  = IW'($urandom);
                mode = 2'($urandom);
                tag  = TW'($urandom);
            end
            rdy  = (i % 1000 < 500) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
            hold = v && (q.size() == 2);
            cycle(v, imm, mode, tag, rdy, ($urandom % 997) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
